// File: rtl/wb_regfile_hilo_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_hilo_pkg
//   Shared constants for the write-back register file slice: default bus
//   widths, the zero word, the hard-wired r0 address and the enable encodings
//   used by the MEM/WB and ID/EX interfaces.
//   Also names the two halves of the HI/LO pair so the HI/LO sub-module can
//   index them symbolically.
// ---------------------------------------------------------------------------
package wb_regfile_hilo_pkg;

  // Bus geometry (GPR/HI/LO data width, GPR address width, GPR count)
  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  // Constant values seen on the pipeline buses
  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic                  WRITE_ENABLE = 1'b1;
  localparam logic                  READ_ENABLE  = 1'b1;
  localparam logic                  READ_DISABLE = 1'b0;

  // HI/LO halves; used as indices into the per-half enable/data vectors
  localparam int NUM_HALVES = 2;
  typedef enum logic {
    HALF_HI = 1'b0,
    HALF_LO = 1'b1
  } hilo_half_e;

endpackage : wb_regfile_hilo_pkg

// File: rtl/wb_regfile_hilo_hilo_reg.sv
// ---------------------------------------------------------------------------
// wb_regfile_hilo_hilo_reg  (the hilo_reg sub-module)
//   Holds the HI and LO registers. Each half has its own write enable, so
//   either, both or neither may commit on a given edge.
//
//   Optional feature (macro REGFILE_BYPASS_EN): when defined, a half being
//   written this cycle shows its incoming value on its output immediately.
//   Without it, outputs always show the stored value.
//
// Ports
//   clk    in   1       pipeline clock, commits on rising edge
//   rst    in   1       asynchronous reset, active-low
//   hi_we  in   1       HI write enable
//   lo_we  in   1       LO write enable
//   hi_i   in   DATA_W  HI write data
//   lo_i   in   DATA_W  LO write data
//   hi_o   out  DATA_W  current HI value (0 while in reset)
//   lo_o   out  DATA_W  current LO value (0 while in reset)
// ---------------------------------------------------------------------------
module wb_regfile_hilo_hilo_reg
  import wb_regfile_hilo_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  // Gather both halves into vectors so one generate loop describes them
  logic [NUM_HALVES-1:0] we_vec;
  logic [DATA_W-1:0]     d_vec [NUM_HALVES];

  assign we_vec[HALF_HI] = hi_we;
  assign we_vec[HALF_LO] = lo_we;
  assign d_vec[HALF_HI]  = hi_i;
  assign d_vec[HALF_LO]  = lo_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HALVES; gi++) begin : g_half
      logic [DATA_W-1:0] q_reg;
      logic [DATA_W-1:0] q_out;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q_reg <= DATA_W'(ZERO_WORD);
        end else if (we_vec[gi] == WRITE_ENABLE) begin
          q_reg <= d_vec[gi];
        end
      end

      // The output is forced to zero while reset is held so that a write
      // presented during reset cannot leak through the bypass path.
      always_comb begin
        q_out = DATA_W'(ZERO_WORD);
        if (rst) begin
`ifdef REGFILE_BYPASS_EN
          if (we_vec[gi] == WRITE_ENABLE) begin
            q_out = d_vec[gi];
          end else begin
            q_out = q_reg;
          end
`else
          q_out = q_reg;
`endif
        end
      end
    end
  endgenerate

  assign hi_o = g_half[HALF_HI].q_out;
  assign lo_o = g_half[HALF_LO].q_out;

endmodule : wb_regfile_hilo_hilo_reg

// File: rtl/wb_regfile_hilo.sv
// ---------------------------------------------------------------------------
// wb_regfile_hilo
//   Write-back end of the MEM->WB path. Holds the general-purpose register
//   file (r0 hard-wired to zero) and the HI/LO pair. Commits MEM/WB results
//   on the rising clock edge, serves two combinational GPR read ports to ID
//   and the HI/LO values to EX.
//
//   Optional feature (macro REGFILE_BYPASS_EN): same-cycle write-through.
//   A read port addressing the register being written this cycle returns
//   the write data instead of the stored value; HI/LO behave the same way.
//   Without it, a write becomes visible the cycle after its commit edge.
//
// Ports
//   clk     in   1       pipeline clock, commits on rising edge
//   rst     in   1       asynchronous reset, active-low
//   we      in   1       GPR write enable (0 = bubble)
//   waddr   in   ADDR_W  GPR write address
//   wdata   in   DATA_W  GPR write data
//   re1     in   1       read port 1 enable
//   raddr1  in   ADDR_W  read port 1 address
//   rdata1  out  DATA_W  read port 1 data (combinational)
//   re2     in   1       read port 2 enable
//   raddr2  in   ADDR_W  read port 2 address
//   rdata2  out  DATA_W  read port 2 data (combinational)
//   hi_we   in   1       HI write enable
//   lo_we   in   1       LO write enable
//   hi_i    in   DATA_W  HI write data
//   lo_i    in   DATA_W  LO write data
//   hi_o    out  DATA_W  current HI value
//   lo_o    out  DATA_W  current LO value
// ---------------------------------------------------------------------------
module wb_regfile_hilo
  import wb_regfile_hilo_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM     // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int NUM_RD_PORTS = 2;

  // -------------------------------------------------------------------------
  // GPR storage. Entry 0 is reset but never written, so it stays zero; the
  // read muxes also decode address 0 explicitly so r0 never depends on it.
  // The array is cleared by the asynchronous reset, so it maps to flops.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic              wr_commit;

  assign wr_commit = (we == WRITE_ENABLE) && (waddr != ADDR_W'(NOP_REG_ADDR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= DATA_W'(ZERO_WORD);
      end
    end else if (wr_commit) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports. Priority: reset, disabled port, r0 -> zero; then the
  // same-cycle write (bypass builds only); then stored state.
  // -------------------------------------------------------------------------
  logic [NUM_RD_PORTS-1:0] re_vec;
  logic [ADDR_W-1:0]       raddr_vec [NUM_RD_PORTS];

  assign re_vec[0]    = re1;
  assign re_vec[1]    = re2;
  assign raddr_vec[0] = raddr1;
  assign raddr_vec[1] = raddr2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      logic [DATA_W-1:0] rd_val;

      always_comb begin
        rd_val = DATA_W'(ZERO_WORD);
        if (!rst || (re_vec[gi] == READ_DISABLE) ||
            (raddr_vec[gi] == ADDR_W'(NOP_REG_ADDR))) begin
          rd_val = DATA_W'(ZERO_WORD);
`ifdef REGFILE_BYPASS_EN
        end else if (wr_commit && (re_vec[gi] == READ_ENABLE) &&
                     (raddr_vec[gi] == waddr)) begin
          // Write-through: the instruction in WB feeds ID in the same cycle
          rd_val = wdata;
`endif
        end else begin
          rd_val = regs_reg[raddr_vec[gi]];
        end
      end
    end
  endgenerate

  assign rdata1 = g_rd[0].rd_val;
  assign rdata2 = g_rd[1].rd_val;

  // -------------------------------------------------------------------------
  // HI/LO pair
  // -------------------------------------------------------------------------
  wb_regfile_hilo_hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_i  (hi_i),
    .lo_i  (lo_i),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

endmodule : wb_regfile_hilo

// File: tb/tb_wb_regfile_hilo.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile_hilo
//   Directed, table-driven bench for wb_regfile_hilo. Each table row holds
//   the inputs for one cycle and the outputs expected just before that
//   cycle's commit edge. Expectations that differ between the plain and the
//   write-through build are selected with the BYP constant. Hand-written
//   sequences cover reset held/released and reset asserted mid-burst.
// ---------------------------------------------------------------------------
module tb_wb_regfile_hilo;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  wb_regfile_hilo dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  function automatic logic [31:0] sel(input bit byp, input logic [31:0] with_byp,
                                      input logic [31:0] without_byp);
    return byp ? with_byp : without_byp;
  endfunction

  function automatic vec_t mk(
    input logic we_v, input logic [4:0] wa, input logic [31:0] wd,
    input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
    input logic hw, input logic lw, input logic [31:0] hd, input logic [31:0] ld,
    input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.we = we_v; v.waddr = wa; v.wdata = wd;
    v.re1 = r1; v.raddr1 = a1; v.re2 = r2; v.raddr2 = a2;
    v.hi_we = hw; v.lo_we = lw; v.hi_i = hd; v.lo_i = ld;
    v.exp_rd1 = e1; v.exp_rd2 = e2; v.exp_hi = eh; v.exp_lo = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    we = v.we; waddr = v.waddr; wdata = v.wdata;
    re1 = v.re1; raddr1 = v.raddr1; re2 = v.re2; raddr2 = v.raddr2;
    hi_we = v.hi_we; lo_we = v.lo_we; hi_i = v.hi_i; lo_i = v.lo_i;
  endtask

  initial begin
    // ----------------------------------------------------------------------
    // Vector table: inputs for one cycle, outputs expected before its edge
    // ----------------------------------------------------------------------
    //            we wa     wdata          r1 a1     r2 a2     hw lw hi_i   lo_i   rd1 / rd2 / hi / lo
    vecs[0]  = mk(1, 5'd7,  32'h1234_5678, 1, 5'd7,  1, 5'd7,  0, 0, 32'h0, 32'h0,
                  sel(BYP, 32'h1234_5678, 32'h0), sel(BYP, 32'h1234_5678, 32'h0), 32'h0, 32'h0);
    vecs[1]  = mk(0, 5'd0,  32'h0,         1, 5'd7,  1, 5'd7,  0, 0, 32'h0, 32'h0,
                  32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0);
    vecs[2]  = mk(1, 5'd0,  32'hFFFF_FFFF, 1, 5'd0,  1, 5'd0,  0, 0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0);
    vecs[3]  = mk(0, 5'd0,  32'h0,         1, 5'd0,  1, 5'd0,  0, 0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0);
    vecs[4]  = mk(1, 5'd9,  32'h1,         1, 5'd9,  1, 5'd7,  0, 0, 32'h0, 32'h0,
                  sel(BYP, 32'h1, 32'h0), 32'h1234_5678, 32'h0, 32'h0);
    vecs[5]  = mk(1, 5'd9,  32'hA5A5_A5A5, 1, 5'd9,  1, 5'd9,  0, 0, 32'h0, 32'h0,
                  sel(BYP, 32'hA5A5_A5A5, 32'h1), sel(BYP, 32'hA5A5_A5A5, 32'h1), 32'h0, 32'h0);
    vecs[6]  = mk(0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd9,  0, 0, 32'h0, 32'h0,
                  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 32'h0);
    vecs[7]  = mk(0, 5'd0,  32'h0,         0, 5'd7,  1, 5'd7,  1, 0, 32'h1, 32'h2,
                  32'h0, 32'h1234_5678, sel(BYP, 32'h1, 32'h0), 32'h0);
    vecs[8]  = mk(0, 5'd0,  32'h0,         1, 5'd7,  0, 5'd7,  0, 0, 32'h9, 32'h9,
                  32'h1234_5678, 32'h0, 32'h1, 32'h0);
    vecs[9]  = mk(0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd7,  1, 1, 32'h3, 32'h4,
                  32'hA5A5_A5A5, 32'h1234_5678, sel(BYP, 32'h3, 32'h1), sel(BYP, 32'h4, 32'h0));
    vecs[10] = mk(0, 5'd0,  32'h0,         1, 5'd31, 1, 5'd9,  0, 0, 32'h0, 32'h0,
                  32'h0, 32'hA5A5_A5A5, 32'h3, 32'h4);
    vecs[11] = mk(1, 5'd31, 32'h8000_0001, 1, 5'd31, 0, 5'd31, 0, 0, 32'h0, 32'h0,
                  sel(BYP, 32'h8000_0001, 32'h0), 32'h0, 32'h3, 32'h4);
    vecs[12] = mk(0, 5'd0,  32'h0,         1, 5'd31, 1, 5'd31, 0, 0, 32'h0, 32'h0,
                  32'h8000_0001, 32'h8000_0001, 32'h3, 32'h4);

    // ----------------------------------------------------------------------
    // Reset held: writes presented during reset are ignored and reads are 0
    // ----------------------------------------------------------------------
    rst = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    hi_we = 1'b1; lo_we = 1'b1; hi_i = 32'h7; lo_i = 32'h8;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_hold_rd1_c%0d", c), rdata1, 32'h0);
      check($sformatf("rst_hold_rd2_c%0d", c), rdata2, 32'h0);
    end
    check("rst_hold_hi", hi_o, 32'h0);
    check("rst_hold_lo", lo_o, 32'h0);

    // Release with a bubble: reg5 must still read 0 afterwards
    @(negedge clk);
    rst = 1'b1;
    we = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    #1;
    check("rst_rel_reg5", rdata1, 32'h0);
    check("rst_rel_hi", hi_o, 32'h0);

    // ----------------------------------------------------------------------
    // Table-driven vectors
    // ----------------------------------------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].exp_rd1);
      check($sformatf("v%0d_rdata2", i), rdata2, vecs[i].exp_rd2);
      check($sformatf("v%0d_hi_o", i), hi_o, vecs[i].exp_hi);
      check($sformatf("v%0d_lo_o", i), lo_o, vecs[i].exp_lo);
    end

    // ----------------------------------------------------------------------
    // Reset asserted mid-burst: outputs drop to 0 with no clock edge
    // ----------------------------------------------------------------------
    @(negedge clk);
    we = 1'b1; waddr = 5'd10; wdata = 32'h0000_0077;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd9;
    hi_we = 1'b0; lo_we = 1'b0;
    #1;
    check("burst_pre_rd1", rdata1, 32'h1234_5678);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_rd1", rdata1, 32'h0);
    check("async_rst_rd2", rdata2, 32'h0);
    check("async_rst_hi", hi_o, 32'h0);
    check("async_rst_lo", lo_o, 32'h0);

    // Release mid-stream with a write presented: state was cleared, the
    // write to reg10 held through reset never landed, and the first edge
    // after release commits reg12.
    @(negedge clk);
    rst = 1'b1;
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0055;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd10;
    #1;
    check("post_rst_reg7", rdata1, 32'h0);
    check("post_rst_reg10", rdata2, 32'h0);
    check("post_rst_hi", hi_o, 32'h0);
    check("post_rst_lo", lo_o, 32'h0);
    @(negedge clk);
    we = 1'b0;
    raddr1 = 5'd12; raddr2 = 5'd12;
    #1;
    check("first_edge_rd1", rdata1, 32'h0000_0055);
    check("first_edge_rd2", rdata2, 32'h0000_0055);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_wb_regfile_hilo
